// File: rtl/eth_hdr_tx.sv
// Ethernet II header serialiser for the TX path: streams dst MAC, src MAC and ethertype as N-bit
// chunks (MSB first), then forwards the payload stream with one cycle of latency.
module eth_hdr_tx #(
  parameter int unsigned N          = 2,
  parameter logic [15:0] ETYPE_IPV4 = 16'h0800,
  parameter logic [15:0] ETYPE_ARP  = 16'h0806
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [47:0]  dst_mac,
  input  logic [47:0]  src_mac,
  input  logic         etype_sel,
  input  logic [N-1:0] axiid,
  input  logic         axiiv,
  output logic         axiir,
  output logic [N-1:0] axiod,
  output logic         axiov,
  output logic         busy,
  output logic         done
);

  localparam int unsigned HDR_CHUNKS  = 112 / N;
  localparam int unsigned MAC_CHUNKS  = 48 / N;
  localparam int unsigned TYPE_CHUNKS = 16 / N;
  localparam int unsigned CW          = $clog2(HDR_CHUNKS) + 1;

  localparam logic [CW-1:0] MAC_LAST  = CW'(MAC_CHUNKS - 1);
  localparam logic [CW-1:0] TYPE_DONE = CW'(TYPE_CHUNKS);

  typedef enum logic [2:0] {
    StIdle,
    StDst,
    StSrc,
    StType,
    StPayload
  } state_t;

  state_t        state;
  logic [CW-1:0] count;
  logic [47:0]   dst_q;
  logic [47:0]   src_q;
  logic [15:0]   etype_q;

  logic [47:0]   field;
  logic [47:0]   field_sh;
  logic [N-1:0]  chunk;

  // Left-align the active field and shift the next chunk into the top N bits.
  always_comb begin
    field = '0;
    unique case (state)
      StDst:   field = dst_q;
      StSrc:   field = src_q;
      StType:  field = {etype_q, 32'h0};
      default: field = '0;
    endcase
    field_sh = field << (N * count);
    chunk    = field_sh[47 -: N];
  end

  // Ready opens while the last ethertype chunk is on the output, so payload follows with no gap.
  assign axiir = ((state == StType) && (count == TYPE_DONE)) || (state == StPayload);
  assign busy  = (state != StIdle);

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= StIdle;
      count   <= '0;
      dst_q   <= '0;
      src_q   <= '0;
      etype_q <= '0;
      axiod   <= '0;
      axiov   <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      if (axiir) begin
        if (axiiv) begin
          axiod <= axiid;
          axiov <= 1'b1;
          state <= StPayload;
          if (count != '1) count <= count + 1'b1;
        end else begin
          axiov <= 1'b0;
          done  <= 1'b1;
          state <= StIdle;
          count <= '0;
        end
      end else begin
        case (state)
          StIdle: begin
            if (start) begin
              dst_q   <= dst_mac;
              src_q   <= src_mac;
              etype_q <= etype_sel ? ETYPE_ARP : ETYPE_IPV4;
              axiod   <= dst_mac[47 -: N];
              axiov   <= 1'b1;
              count   <= CW'(1);
              state   <= StDst;
            end
          end
          StDst: begin
            axiod <= chunk;
            axiov <= 1'b1;
            if (count == MAC_LAST) begin
              state <= StSrc;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          StSrc: begin
            axiod <= chunk;
            axiov <= 1'b1;
            if (count == MAC_LAST) begin
              state <= StType;
              count <= '0;
            end else begin
              count <= count + 1'b1;
            end
          end
          StType: begin
            axiod <= chunk;
            axiov <= 1'b1;
            count <= count + 1'b1;
          end
          default: begin
            state <= StIdle;
            count <= '0;
            axiov <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_eth_hdr_tx.sv
// Directed self-checking bench for eth_hdr_tx (N=2): header layout, payload pass-through,
// underrun, ignored restarts, mid-frame reset and back-to-back frames.
module tb_eth_hdr_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [47:0] dst_mac;
  logic [47:0] src_mac;
  logic        etype_sel;
  logic [1:0]  axiid;
  logic        axiiv;
  logic        axiir;
  logic [1:0]  axiod;
  logic        axiov;
  logic        busy;
  logic        done;

  eth_hdr_tx #(.N(2)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .dst_mac  (dst_mac),
    .src_mac  (src_mac),
    .etype_sel(etype_sel),
    .axiid    (axiid),
    .axiiv    (axiiv),
    .axiir    (axiir),
    .axiod    (axiod),
    .axiov    (axiov),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int         total  = 0;
  int         passed = 0;
  logic [1:0] cap[$];
  logic [1:0] pay[4] = '{2'b01, 2'b10, 2'b11, 2'b00};
  int         ready_cnt, done_cnt;
  logic       first_ov, post_ov, post_busy;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts a frame from the current negedge and records every valid chunk until done
  // (or a few cycles after an injected reset). Returns at the negedge of the done cycle.
  task automatic run_frame(input logic [47:0] d, input logic [47:0] s, input logic sel,
                           input int npay, input int pert_k, input int rst_k);
    int pay_i;
    bit fin;
    cap.delete();
    ready_cnt = 0;
    done_cnt  = 0;
    pay_i     = 0;
    fin       = 0;
    dst_mac   = d;
    src_mac   = s;
    etype_sel = sel;
    start     = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    first_ov = axiov;
    for (int k = 0; k < 300 && !fin; k++) begin
      if (k == rst_k + 1) begin
        post_ov   = axiov;
        post_busy = busy;
      end
      if (axiov) cap.push_back(axiod);
      if (axiir) ready_cnt++;
      if (done) begin
        done_cnt++;
        fin = 1;
      end
      start = 1'b0;
      rst   = 1'b0;
      if (k == pert_k) begin
        start     = 1'b1;
        dst_mac   = 48'h0102_0304_0506;
        src_mac   = 48'hA5A5_A5A5_A5A5;
        etype_sel = ~sel;
      end
      if (rst_k >= 0 && k == rst_k) rst = 1'b1;
      if (rst_k >= 0 && k == rst_k + 3) fin = 1;
      axiiv = 1'b0;
      if (axiir && pay_i < npay) begin
        axiiv = 1'b1;
        axiid = pay[pay_i];
        pay_i++;
      end
      if (!fin) @(negedge clk);
    end
    chk("frame_end_reached", 32'(fin), 32'd1);
  endtask

  task automatic check_frame(input string tag, input logic [47:0] d, input logic [47:0] s,
                             input logic sel, input int npay);
    logic [111:0] hdr;
    logic [1:0]   exp;
    int           bad;
    hdr = {d, s, (sel ? 16'h0806 : 16'h0800)};
    bad = 0;
    chk({tag, "_len"}, 32'(cap.size()), 32'(56 + npay));
    for (int i = 0; i < cap.size() && i < 56 + npay; i++) begin
      exp = (i < 56) ? hdr[111 - 2*i -: 2] : pay[i - 56];
      if (cap[i] !== exp) bad++;
    end
    chk({tag, "_chunk_errs"}, 32'(bad), 32'd0);
    chk({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
  endtask

  logic [1:0]  et_arp[8] = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b01, 2'b10};
  logic [1:0]  et_ip[8]  = '{2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00};
  logic [1:0]  src_head[4] = '{2'b00, 2'b01, 2'b00, 2'b10};
  logic [15:0] rx_etype;
  int          bad;

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    dst_mac   = '0;
    src_mac   = '0;
    etype_sel = 1'b0;
    axiid     = '0;
    axiiv     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_axiov", 32'(axiov), 32'd0);
    chk("rst_axiod", 32'(axiod), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_axiir", 32'(axiir), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: broadcast ARP frame, 4 payload chunks
    run_frame(48'hFFFF_FFFF_FFFF, 48'h1234_5678_9ABC, 1'b1, 4, -1, -1);
    chk("t1_first_chunk_latency", 32'(first_ov), 32'd1);
    chk("t1_len", 32'(cap.size()), 32'd60);
    bad = 0;
    for (int i = 0; i < 24 && i < cap.size(); i++) if (cap[i] !== 2'b11) bad++;
    chk("t1_dst_all_ones", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 4 && 24 + i < cap.size(); i++) if (cap[24+i] !== src_head[i]) bad++;
    chk("t1_src_head", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 8 && 48 + i < cap.size(); i++) if (cap[48+i] !== et_arp[i]) bad++;
    chk("t1_etype_arp", 32'(bad), 32'd0);
    bad = 0;
    for (int i = 0; i < 4 && 56 + i < cap.size(); i++) if (cap[56+i] !== pay[i]) bad++;
    chk("t1_payload", 32'(bad), 32'd0);
    chk("t1_ready_cycles", 32'(ready_cnt), 32'd5);
    chk("t1_done_pulses", 32'(done_cnt), 32'd1);
    chk("t1_done_axiov_low", 32'(axiov), 32'd0);
    @(negedge clk);
    chk("t1_done_one_cycle", 32'(done), 32'd0);
    chk("t1_idle_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge clk);

    // 2: IPv4 ethertype and a receive-side classification of the looped-back header
    run_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b0, 2, -1, -1);
    check_frame("t2_ipv4", 48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b0, 2);
    bad = 0;
    rx_etype = '0;
    for (int i = 0; i < 8 && 48 + i < cap.size(); i++) begin
      if (cap[48+i] !== et_ip[i]) bad++;
      rx_etype = {rx_etype[13:0], cap[48+i]};
    end
    chk("t2_etype_ipv4", 32'(bad), 32'd0);
    chk("t2_rx_class_ipv4", 32'(rx_etype == 16'h0806), 32'd0);
    repeat (2) @(negedge clk);
    run_frame(48'h0011_2233_4455, 48'h6677_8899_AABB, 1'b1, 2, -1, -1);
    rx_etype = '0;
    for (int i = 0; i < 8 && 48 + i < cap.size(); i++) rx_etype = {rx_etype[13:0], cap[48+i]};
    chk("t2_rx_class_arp", 32'(rx_etype == 16'h0806), 32'd1);
    repeat (2) @(negedge clk);

    // 3: payload source underrun on the first ready cycle
    run_frame(48'hDEAD_BEEF_0001, 48'h0203_0405_0607, 1'b0, 0, -1, -1);
    check_frame("t3_hdr_only", 48'hDEAD_BEEF_0001, 48'h0203_0405_0607, 1'b0, 0);
    chk("t3_ready_cycles", 32'(ready_cnt), 32'd1);
    repeat (2) @(negedge clk);

    // 4: restart request mid-header with different fields is ignored
    run_frame(48'hC0FF_EE00_1122, 48'h3344_5566_7788, 1'b1, 3, 10, -1);
    check_frame("t4_restart_ignored", 48'hC0FF_EE00_1122, 48'h3344_5566_7788, 1'b1, 3);
    repeat (3) @(negedge clk);
    chk("t4_no_extra_frame", 32'(busy), 32'd0);

    // 5: reset at header chunk 30 truncates the frame without done
    run_frame(48'hFEDC_BA98_7654, 48'h0123_4567_89AB, 1'b0, 2, -1, 30);
    chk("t5_axiov_after_rst", 32'(post_ov), 32'd0);
    chk("t5_busy_after_rst", 32'(post_busy), 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'd0);
    chk("t5_truncated_len", 32'(cap.size()), 32'd31);
    @(negedge clk);
    run_frame(48'hFEDC_BA98_7654, 48'h0123_4567_89AB, 1'b0, 2, -1, -1);
    check_frame("t5_clean_after", 48'hFEDC_BA98_7654, 48'h0123_4567_89AB, 1'b0, 2);
    repeat (2) @(negedge clk);

    // 6: back-to-back frames, second start in the done cycle
    run_frame(48'h1111_2222_3333, 48'h4444_5555_6666, 1'b1, 2, -1, -1);
    check_frame("t6_frame_a", 48'h1111_2222_3333, 48'h4444_5555_6666, 1'b1, 2);
    run_frame(48'hAAAA_BBBB_CCCC, 48'h0F0F_0F0F_0F0F, 1'b0, 4, -1, -1);
    chk("t6_b_starts_next_cycle", 32'(first_ov), 32'd1);
    check_frame("t6_frame_b", 48'hAAAA_BBBB_CCCC, 48'h0F0F_0F0F_0F0F, 1'b0, 4);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
